// File: rtl/gate_sequencer_if.sv
// Handshake and gate-under-test signals for gate_sequencer.
// The slave side is the sequencer; the master side is whatever drives start/abort and owns the gate.
interface gate_sequencer_if;
  logic       start;
  logic       abort;
  logic       dut_y;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_count;
  logic [3:0] fail_vec;

  modport slave (
    input  start, abort, dut_y,
    output dut_a, dut_b, busy, done, pass, fail_count, fail_vec
  );

  modport master (
    output start, abort, dut_y,
    input  dut_a, dut_b, busy, done, pass, fail_count, fail_vec
  );
endinterface

// File: rtl/gate_sequencer.sv
// Walks the four input vectors of a 2-input gate, waits SETTLE_CYCLES, samples the
// output against TRUTH[{b,a}] and reports pass/fail plus a per-vector failure map.
module gate_sequencer #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] TRUTH         = 4'b0111
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dut_a_q, dut_a_d;
  logic       dut_b_q, dut_b_d;
  logic       pass_q, pass_d;
  logic [2:0] fail_count_q, fail_count_d;
  logic [3:0] fail_vec_q, fail_vec_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 8'd0;
      dut_a_q      <= 1'b0;
      dut_b_q      <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 3'd0;
      fail_vec_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      dut_a_q      <= dut_a_d;
      dut_b_q      <= dut_b_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    dut_a_d      = dut_a_q;
    dut_b_d      = dut_b_q;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    fail_vec_d   = fail_vec_q;

    // abort outranks everything once a run is in flight, DONE included
    if (bus.abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      dut_a_d      = 1'b0;
      dut_b_d      = 1'b0;
      pass_d       = 1'b0;
      fail_count_d = 3'd0;
      fail_vec_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
          if (bus.start && !bus.abort) begin
            state_d      = APPLY;
            idx_d        = 2'd0;
            pass_d       = 1'b0;
            fail_count_d = 3'd0;
            fail_vec_d   = 4'd0;
          end
        end
        APPLY: begin
          cnt_d   = SETTLE_M1;
          state_d = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == 8'd0) state_d = SAMPLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        SAMPLE: begin
          if (bus.dut_y != TRUTH[idx_q]) begin
            fail_vec_d[idx_q] = 1'b1;
            fail_count_d      = fail_count_q + 3'd1;
          end
          // pass is settled on entry to DONE so it is valid alongside the done pulse
          if (idx_q == 2'd3) begin
            state_d = DONE;
            dut_a_d = 1'b0;
            dut_b_d = 1'b0;
            pass_d  = (fail_vec_d == 4'd0);
          end else begin
            idx_d   = idx_q + 2'd1;
            dut_a_d = idx_d[0];
            dut_b_d = idx_d[1];
            state_d = APPLY;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.dut_a      = dut_a_q;
  assign bus.dut_b      = dut_b_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.fail_count = fail_count_q;
  assign bus.fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: a default NAND instance and an AND/SETTLE=1 instance,
// each driven by a behavioural gate whose fault mode the scenarios select.
module tb_gate_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;
  int   mode0 = 0;  // 0 NAND, 1 stuck-at-1, 2 stuck-at-0, 3 AND
  int   mode1 = 3;

  always #5 clk = ~clk;

  gate_sequencer_if if0 ();
  gate_sequencer_if if1 ();

  function automatic logic gate_y(input int mode, input logic a, input logic b);
    case (mode)
      0:       return ~(a & b);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return a & b;
    endcase
  endfunction

  assign if0.dut_y = gate_y(mode0, if0.dut_a, if0.dut_b);
  assign if1.dut_y = gate_y(mode1, if1.dut_a, if1.dut_b);

  gate_sequencer u_nand (.clk(clk), .rst_n(rst_n), .bus(if0));
  gate_sequencer #(.SETTLE_CYCLES(1), .TRUTH(4'b1000)) u_and (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic test_reset();
    rst_n = 1'b1; if0.start = 1'b1; if0.abort = 1'b0; if1.start = 1'b1; if1.abort = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if ({if0.dut_a, if0.dut_b, if0.busy, if0.done, if0.pass, if0.fail_count, if0.fail_vec} !== 11'd0) begin
      errs++; $display("FAIL reset_async: got %b want 0", {if0.dut_a, if0.dut_b, if0.busy, if0.done, if0.pass, if0.fail_count, if0.fail_vec});
    end
    vecs++;
    if ({if1.busy, if1.done, if1.pass, if1.fail_count, if1.fail_vec} !== 9'd0) begin
      errs++; $display("FAIL reset_async_and: got %b want 0", {if1.busy, if1.done, if1.pass, if1.fail_count, if1.fail_vec});
    end
    repeat (2) @(negedge clk);
    if0.start = 1'b0; if1.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin
      errs++; $display("FAIL reset_release: busy=%b done=%b want 0 0", if0.busy, if0.done);
    end
  endtask

  task automatic test_good_nand();
    logic [1:0] v;
    mode0 = 0;
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    for (int n = 0; n < 18; n++) begin
      if (n < 16) begin
        v = 2'(n / 4);
        vecs++;
        if (if0.dut_a !== v[0] || if0.dut_b !== v[1] || if0.busy !== 1'b1 || if0.done !== 1'b0) begin
          errs++; $display("FAIL nand_cycle%0d: a=%b b=%b busy=%b done=%b want %b %b 1 0", n, if0.dut_a, if0.dut_b, if0.busy, if0.done, v[0], v[1]);
        end
      end else if (n == 16) begin
        vecs++;
        if (if0.done !== 1'b1 || if0.pass !== 1'b1 || if0.fail_count !== 3'd0 || if0.fail_vec !== 4'b0000) begin
          errs++; $display("FAIL nand_done: done=%b pass=%b fc=%0d fv=%b want 1 1 0 0000", if0.done, if0.pass, if0.fail_count, if0.fail_vec);
        end
      end else begin
        vecs++;
        if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.dut_a !== 1'b0 || if0.pass !== 1'b1) begin
          errs++; $display("FAIL nand_after: done=%b busy=%b a=%b pass=%b want 0 0 0 1", if0.done, if0.busy, if0.dut_a, if0.pass);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stuck();
    int n;
    for (int k = 0; k < 2; k++) begin
      mode0 = (k == 0) ? 1 : 2;
      @(negedge clk) if0.start = 1'b1;
      @(negedge clk) if0.start = 1'b0;
      n = 0;
      while (if0.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      vecs++;
      if (n != 16) begin errs++; $display("FAIL stuck%0d_latency: got %0d want 16", k, n); end
      vecs++;
      if (k == 0 && (if0.pass !== 1'b0 || if0.fail_count !== 3'd1 || if0.fail_vec !== 4'b1000)) begin
        errs++; $display("FAIL stuck1_result: pass=%b fc=%0d fv=%b want 0 1 1000", if0.pass, if0.fail_count, if0.fail_vec);
      end
      if (k == 1 && (if0.pass !== 1'b0 || if0.fail_count !== 3'd3 || if0.fail_vec !== 4'b0111)) begin
        errs++; $display("FAIL stuck0_result: pass=%b fc=%0d fv=%b want 0 3 0111", if0.pass, if0.fail_count, if0.fail_vec);
      end
      @(negedge clk);
    end
    mode0 = 0;
  endtask

  task automatic test_and_gate();
    int n;
    for (int k = 0; k < 2; k++) begin
      mode1 = (k == 0) ? 3 : 0;
      @(negedge clk) if1.start = 1'b1;
      @(negedge clk) if1.start = 1'b0;
      n = 0;
      while (if1.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      vecs++;
      if (n != 12) begin errs++; $display("FAIL and%0d_latency: got %0d want 12", k, n); end
      vecs++;
      if (k == 0 && (if1.pass !== 1'b1 || if1.fail_count !== 3'd0 || if1.fail_vec !== 4'b0000)) begin
        errs++; $display("FAIL and_good: pass=%b fc=%0d fv=%b want 1 0 0000", if1.pass, if1.fail_count, if1.fail_vec);
      end
      if (k == 1 && (if1.pass !== 1'b0 || if1.fail_count !== 3'd4 || if1.fail_vec !== 4'b1111)) begin
        errs++; $display("FAIL and_nand_dut: pass=%b fc=%0d fv=%b want 0 4 1111", if1.pass, if1.fail_count, if1.fail_vec);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_abort();
    int n;
    bit seen_done;
    mode0 = 2;
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    repeat (4) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (if0.dut_a !== 1'b0 || if0.dut_b !== 1'b1 || if0.busy !== 1'b1) begin
      errs++; $display("FAIL busy_start_ignored: a=%b b=%b busy=%b want 0 1 1", if0.dut_a, if0.dut_b, if0.busy);
    end
    @(negedge clk);
    vecs++;
    if (if0.fail_count !== 3'd2 || if0.fail_vec !== 4'b0011) begin
      errs++; $display("FAIL pre_abort: fc=%0d fv=%b want 2 0011", if0.fail_count, if0.fail_vec);
    end
    if0.abort = 1'b1;
    @(negedge clk) if0.abort = 1'b0;
    vecs++;
    if ({if0.busy, if0.done, if0.pass, if0.fail_count, if0.fail_vec, if0.dut_a, if0.dut_b} !== 11'd0) begin
      errs++; $display("FAIL abort_clear: got %b want 0", {if0.busy, if0.done, if0.pass, if0.fail_count, if0.fail_vec, if0.dut_a, if0.dut_b});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (if0.done === 1'b1) seen_done = 1'b1; end
    vecs++;
    if (seen_done) begin errs++; $display("FAIL abort_no_done: got done pulse want none"); end
    mode0 = 0;
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    n = 0;
    while (if0.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    vecs++;
    if (n != 16 || if0.pass !== 1'b1) begin
      errs++; $display("FAIL rerun_after_abort: cycles=%0d pass=%b want 16 1", n, if0.pass);
    end
    @(negedge clk);
    if0.start = 1'b1; if0.abort = 1'b1;
    @(negedge clk) begin if0.start = 1'b0; if0.abort = 1'b0; end
    vecs++;
    if (if0.busy !== 1'b0) begin errs++; $display("FAIL abort_start_idle: busy=%b want 0", if0.busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    mode0 = 0;
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk);
    n = 0;
    while (if0.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    vecs++;
    if (n != 16 || if0.pass !== 1'b1) begin errs++; $display("FAIL b2b_first: cycles=%0d pass=%b want 16 1", n, if0.pass); end
    @(negedge clk);
    vecs++;
    if (if0.busy !== 1'b0 || if0.pass !== 1'b1) begin
      errs++; $display("FAIL b2b_gap: busy=%b pass=%b want 0 1", if0.busy, if0.pass);
    end
    @(negedge clk);
    vecs++;
    if (if0.busy !== 1'b1 || if0.pass !== 1'b0) begin
      errs++; $display("FAIL b2b_restart: busy=%b pass=%b want 1 0", if0.busy, if0.pass);
    end
    if0.start = 1'b0; if0.abort = 1'b1;
    @(negedge clk) if0.abort = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    mode0 = 2;
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    repeat (7) @(negedge clk);
    vecs++;
    if (if0.fail_count !== 3'd1 || if0.dut_a !== 1'b1) begin
      errs++; $display("FAIL pre_reset: fc=%0d a=%b want 1 1", if0.fail_count, if0.dut_a);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({if0.dut_a, if0.dut_b, if0.busy, if0.done, if0.pass, if0.fail_count, if0.fail_vec} !== 11'd0) begin
      errs++; $display("FAIL reset_midrun: got %b want 0", {if0.dut_a, if0.dut_b, if0.busy, if0.done, if0.pass, if0.fail_count, if0.fail_vec});
    end
    @(negedge clk) rst_n = 1'b1;
    mode0 = 0;
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    vecs++;
    if (if0.dut_a !== 1'b0 || if0.dut_b !== 1'b0 || if0.busy !== 1'b1) begin
      errs++; $display("FAIL reset_rerun_vec0: a=%b b=%b busy=%b want 0 0 1", if0.dut_a, if0.dut_b, if0.busy);
    end
    n = 0;
    while (if0.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    vecs++;
    if (n != 16 || if0.pass !== 1'b1 || if0.fail_vec !== 4'b0000) begin
      errs++; $display("FAIL reset_rerun: cycles=%0d pass=%b fv=%b want 16 1 0000", n, if0.pass, if0.fail_vec);
    end
  endtask

  initial begin
    test_reset();
    test_good_nand();
    test_stuck();
    test_and_gate();
    test_start_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
